// File: rtl/scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
// Shared types and constants for the scoreboard seven-segment display path.
//   bcd_t   : one BCD score digit (codes 10..15 are treated as invalid)
//   seg_t   : seven-segment pattern, bit order {g,f,e,d,c,b,a}, logic-high = lit
//   slot_t  : digit slot index; slot 0 is the rightmost digit on the display
// -----------------------------------------------------------------------------
package scoreboard_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] slot_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  // Scan order: away score on the right, home score on the left.
  localparam slot_t SLOT_AWAY_U = 2'd0;
  localparam slot_t SLOT_AWAY_T = 2'd1;
  localparam slot_t SLOT_HOME_U = 2'd2;
  localparam slot_t SLOT_HOME_T = 2'd3;

  // Tens slots are the only ones subject to leading-zero blanking.
  function automatic logic is_tens_slot(input slot_t s);
    return (s == SLOT_AWAY_T) || (s == SLOT_HOME_T);
  endfunction

endpackage

// File: rtl/scoreboard_display_driver_if.sv
// -----------------------------------------------------------------------------
// scoreboard_display_driver_if
// Bundles the score inputs and the LED display outputs of the display driver.
//   home_bcd1/home_bcd0 : home tens / units       (master -> slave)
//   away_bcd1/away_bcd0 : away tens / units       (master -> slave)
//   blank_lz            : blank a zero tens digit (master -> slave)
//   blink               : blink whole display     (master -> slave)
//   seg/dp/an           : registered display drive (slave -> master)
//   frame_start         : one-cycle frame pulse    (slave -> master)
// Handshake: there is no valid/ready pair. Score inputs are levels that the
// slave samples only on its internal snapshot edge once per frame; the
// master may change them at any time and frame_start tells it when the last
// sample was taken.
// -----------------------------------------------------------------------------
interface scoreboard_display_driver_if;
  import scoreboard_pkg::*;

  bcd_t       home_bcd1;
  bcd_t       home_bcd0;
  bcd_t       away_bcd1;
  bcd_t       away_bcd0;
  logic       blank_lz;
  logic       blink;
  seg_t       seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  modport master (
    output home_bcd1, home_bcd0, away_bcd1, away_bcd0, blank_lz, blink,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  home_bcd1, home_bcd0, away_bcd1, away_bcd0, blank_lz, blink,
    output seg, dp, an, frame_start
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational 4-bit code to seven-segment pattern decoder.
//   code    in  4  BCD code; 10..15 decode to a dash
//   pattern out 7  {g,f,e,d,c,b,a}, logic-high = lit
// -----------------------------------------------------------------------------
module bcd_to_7seg
  import scoreboard_pkg::*;
(
  input  bcd_t code,
  output seg_t pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/scoreboard_display_driver.sv
// -----------------------------------------------------------------------------
// scoreboard_display_driver
// Time-multiplexed four-digit seven-segment driver for the home/away scores.
// Each digit owns a slot of CLKS_PER_DIGIT clocks; the first BLANK_CLKS of a
// slot keep every anode off to hide ghosting while the segment bus settles.
// Scores are copied into shadow registers once per frame (end of slot 3) so
// the display never tears mid-scan.
//   clk    in   clock
//   reset  in   asynchronous, active-high; blanks the display immediately
//   bus    slave modport of scoreboard_display_driver_if
// Parameters:
//   CLKS_PER_DIGIT >= 4, 1 <= BLANK_CLKS < CLKS_PER_DIGIT,
//   BLINK_FRAMES frames per blink half-period, SEG_ACTIVE_LOW output polarity.
// -----------------------------------------------------------------------------
module scoreboard_display_driver
  import scoreboard_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int BLANK_CLKS     = 16,
  parameter int BLINK_FRAMES   = 125,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  scoreboard_display_driver_if.slave bus
);

  localparam int PW = $clog2(CLKS_PER_DIGIT);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PCNT_LAST  = PW'(CLKS_PER_DIGIT - 1);
  localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CLKS);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

  // XOR masks that turn logical "active" into the physical pin level.
  localparam seg_t       SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] AN_INV  = {4{SEG_ACTIVE_LOW}};
  localparam logic       DP_INV  = SEG_ACTIVE_LOW;

  logic [PW-1:0] pcnt_q, pcnt_d;
  slot_t         idx_q, idx_d;
  bcd_t          sh_home1_q, sh_home1_d;
  bcd_t          sh_home0_q, sh_home0_d;
  bcd_t          sh_away1_q, sh_away1_d;
  bcd_t          sh_away0_q, sh_away0_d;
  logic          sh_blank_lz_q, sh_blank_lz_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_on_q, phase_on_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_start_q, frame_start_d;

  logic  pcnt_last;
  logic  snap;
  logic  display_on;
  logic  active;
  logic  lz_blank;
  bcd_t  cur_digit;
  seg_t  dec_seg;

  // Shadow mux feeding the single shared decoder.
  always_comb begin
    cur_digit = sh_away0_q;
    case (idx_q)
      SLOT_AWAY_U: cur_digit = sh_away0_q;
      SLOT_AWAY_T: cur_digit = sh_away1_q;
      SLOT_HOME_U: cur_digit = sh_home0_q;
      SLOT_HOME_T: cur_digit = sh_home1_q;
      default:     cur_digit = sh_away0_q;
    endcase
  end

  bcd_to_7seg u_dec (
    .code    (cur_digit),
    .pattern (dec_seg)
  );

  always_comb begin
    pcnt_d        = pcnt_q;
    idx_d         = idx_q;
    sh_home1_d    = sh_home1_q;
    sh_home0_d    = sh_home0_q;
    sh_away1_d    = sh_away1_q;
    sh_away0_d    = sh_away0_q;
    sh_blank_lz_d = sh_blank_lz_q;
    fcnt_d        = fcnt_q;
    phase_on_d    = phase_on_q;

    pcnt_last = (pcnt_q == PCNT_LAST);
    snap      = pcnt_last && (idx_q == SLOT_HOME_T);

    // Prescaler and slot index; idx wraps 3 -> 0 naturally in 2 bits.
    pcnt_d = pcnt_last ? '0 : pcnt_q + 1'b1;
    if (pcnt_last) begin
      idx_d = idx_q + 1'b1;
    end

    if (snap) begin
      sh_home1_d    = bus.home_bcd1;
      sh_home0_d    = bus.home_bcd0;
      sh_away1_d    = bus.away_bcd1;
      sh_away0_d    = bus.away_bcd0;
      sh_blank_lz_d = bus.blank_lz;
    end

    // Blink counts frame boundaries only while blink is requested.
    if (!bus.blink) begin
      fcnt_d     = '0;
      phase_on_d = 1'b1;
    end else if (snap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d     = '0;
        phase_on_d = !phase_on_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Using the live blink level lets the display come back on the very
    // next cycle after blink drops, without waiting for phase_on_q.
    display_on = phase_on_q || !bus.blink;
    active     = (pcnt_q >= PCNT_BLANK) && display_on;
    lz_blank   = sh_blank_lz_q && is_tens_slot(idx_q) && (cur_digit == 4'd0);

    an_d          = (active ? (4'b0001 << idx_q) : 4'b0000) ^ AN_INV;
    seg_d         = ((active && !lz_blank) ? dec_seg : SEG_OFF) ^ SEG_INV;
    dp_d          = (active && (idx_q == SLOT_HOME_U)) ^ DP_INV;
    frame_start_d = snap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q        <= '0;
      idx_q         <= SLOT_AWAY_U;
      sh_home1_q    <= '0;
      sh_home0_q    <= '0;
      sh_away1_q    <= '0;
      sh_away0_q    <= '0;
      sh_blank_lz_q <= 1'b0;
      fcnt_q        <= '0;
      phase_on_q    <= 1'b1;
      seg_q         <= SEG_INV;
      dp_q          <= DP_INV;
      an_q          <= AN_INV;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      sh_home1_q    <= sh_home1_d;
      sh_home0_q    <= sh_home0_d;
      sh_away1_q    <= sh_away1_d;
      sh_away0_q    <= sh_away0_d;
      sh_blank_lz_q <= sh_blank_lz_d;
      fcnt_q        <= fcnt_d;
      phase_on_q    <= phase_on_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_scoreboard_display_driver.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_display_driver
// Self-checking bench for scoreboard_display_driver with small timing
// parameters. Vectors hold input scores and the hand-derived pattern for
// each slot; expected {an,seg,dp,frame_start} words for a whole frame are
// queued when a frame starts and popped cycle by cycle.
// -----------------------------------------------------------------------------
module tb_scoreboard_display_driver;
  import scoreboard_pkg::*;

  localparam int CPD   = 8;
  localparam int BLK   = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * CPD;

  typedef struct packed {
    logic [3:0]      h1;
    logic [3:0]      h0;
    logic [3:0]      a1;
    logic [3:0]      a0;
    logic            blz;
    logic [3:0][6:0] seg;  // seg[s] = expected pattern in slot s
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scoreboard_display_driver_if bus ();

  scoreboard_display_driver #(
    .CLKS_PER_DIGIT (CPD),
    .BLANK_CLKS     (BLK),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  logic [6:0] seg_lut [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [12:0] observed();
    return {bus.an, bus.seg, bus.dp, bus.frame_start};
  endfunction

  function automatic vec_t mk(input logic [3:0] h1, h0, a1, a0, input logic blz,
                              input logic [6:0] s3, s2, s1, s0);
    vec_t v;
    v.h1 = h1; v.h0 = h0; v.a1 = a1; v.a0 = a0; v.blz = blz;
    v.seg = {s3, s2, s1, s0};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input vec_t v);
    bus.home_bcd1 = v.h1;
    bus.home_bcd0 = v.h0;
    bus.away_bcd1 = v.a1;
    bus.away_bcd0 = v.a0;
    bus.blank_lz  = v.blz;
  endtask

  // Advance to the next frame_start pulse (at least one cycle forward).
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 100);
    chk("frame_start_seen", 32'(bus.frame_start), 32'd1);
  endtask

  // Called while frame_start is high. Checks the following frame cycle by
  // cycle. Display is expected on from cycle on_from_k; at cycle act_k the
  // action act is performed after the compare (1: away units -> 5,
  // 2: drop blink).
  task automatic check_frame(input vec_t v, input int on_from_k, input int act_k,
                             input int act, input string name);
    for (int k = 1; k <= FRAME; k++) begin
      int p = (k - 1) % CPD;
      int s = (k - 1) / CPD;
      logic [3:0] oh;
      logic fs;
      oh = 4'b0001 << s;
      fs = (k == FRAME);
      if (p >= BLK && k >= on_from_k)
        exp_q.push_back({oh, v.seg[s], (s == 2), fs});
      else
        exp_q.push_back({4'b0000, 7'h00, 1'b0, fs});
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk($sformatf("%s k=%0d", name, k), 32'(observed()), 32'(exp_q.pop_front()));
      if (k == act_k) begin
        if (act == 1) bus.away_bcd0 = 4'd5;
        if (act == 2) bus.blink = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs [5];
    vec_t zero_v, v0, v0b, v2, rv;
    int n;

    seg_lut[0] = 7'h3F;  seg_lut[1] = 7'h06;  seg_lut[2] = 7'h5B;  seg_lut[3] = 7'h4F;
    seg_lut[4] = 7'h66;  seg_lut[5] = 7'h6D;  seg_lut[6] = 7'h7D;  seg_lut[7] = 7'h07;
    seg_lut[8] = 7'h7F;  seg_lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) seg_lut[i] = 7'h40;

    zero_v  = mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    v0      = mk(4'd4, 4'd2, 4'd0, 4'd7, 1'b0, 7'h66, 7'h5B, 7'h3F, 7'h07);
    v0b     = mk(4'd4, 4'd2, 4'd0, 4'd5, 1'b0, 7'h66, 7'h5B, 7'h3F, 7'h6D);
    v2      = mk(4'd1, 4'd9, 4'd3, 4'hC, 1'b0, 7'h06, 7'h6F, 7'h4F, 7'h40);
    vecs[0] = v0;
    vecs[1] = mk(4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 7'h00, 7'h6D, 7'h00, 7'h3F);
    vecs[2] = v2;
    vecs[3] = mk(4'hF, 4'd8, 4'hA, 4'd6, 1'b1, 7'h40, 7'h7F, 7'h40, 7'h7D);
    vecs[4] = mk(4'd0, 4'd0, 4'd9, 4'd0, 1'b1, 7'h00, 7'h3F, 7'h6F, 7'h3F);

    apply(zero_v);
    bus.blink = 1'b0;
    reset = 1'b1;

    // Reset held: everything inactive.
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(bus.an), 32'h0);
    chk("reset_seg", 32'(bus.seg), 32'h00);
    chk("reset_dp", 32'(bus.dp), 32'h0);
    chk("reset_frame_start", 32'(bus.frame_start), 32'h0);

    // Release: an[0] appears at edge BLK+1, frame_start at edge 32.
    reset = 1'b0;
    @(negedge clk);
    chk("release_edge1", 32'(observed()), 32'h0);
    @(negedge clk);
    chk("release_edge2", 32'(observed()), 32'h0);
    @(negedge clk);
    chk("release_edge3", 32'(observed()), 32'({4'b0001, 7'h3F, 1'b0, 1'b0}));
    n = 3;
    while (!bus.frame_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_frame_start_edge", 32'(n), 32'd32);
    check_frame(zero_v, 1, 0, 0, "zero_frame");

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i]);
      wait_fs();
      check_frame(vecs[i], 1, 0, 0, $sformatf("vec%0d", i));
    end

    // Mid-frame input change must not tear the current frame.
    apply(v0);
    wait_fs();
    check_frame(v0, 1, 4, 1, "no_tear");
    check_frame(v0b, 1, 0, 0, "after_change");

    // Random scores, expected from the bench pattern table.
    for (int i = 0; i < 3; i++) begin
      rv.h1  = 4'($urandom_range(0, 15));
      rv.h0  = 4'($urandom_range(0, 15));
      rv.a1  = 4'($urandom_range(0, 15));
      rv.a0  = 4'($urandom_range(0, 15));
      rv.blz = 1'($urandom_range(0, 1));
      rv.seg[3] = (rv.blz && rv.h1 == 4'd0) ? 7'h00 : seg_lut[rv.h1];
      rv.seg[2] = seg_lut[rv.h0];
      rv.seg[1] = (rv.blz && rv.a1 == 4'd0) ? 7'h00 : seg_lut[rv.a1];
      rv.seg[0] = seg_lut[rv.a0];
      apply(rv);
      wait_fs();
      check_frame(rv, 1, 0, 0, $sformatf("rand%0d", i));
    end

    // Reset mid-slot blanks immediately.
    apply(v2);
    wait_fs();
    repeat (12) @(negedge clk);
    chk("pre_reset_slot1", 32'(observed()), 32'({4'b0010, 7'h4F, 1'b0, 1'b0}));
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(observed()), 32'h0);
    @(negedge clk);
    chk("reset_hold_outputs", 32'(observed()), 32'h0);
    reset = 1'b0;
    wait_fs();
    check_frame(v2, 1, 0, 0, "post_reset");

    // Blink: two frames on, two off; dropping blink restores next cycle.
    apply(v0);
    wait_fs();
    bus.blink = 1'b1;
    check_frame(v0, 1, 0, 0, "blink_on_a");
    check_frame(v0, 1, 0, 0, "blink_on_b");
    check_frame(v0, FRAME + 1, 0, 0, "blink_off_c");
    check_frame(v0, 11, 10, 2, "blink_release");
    check_frame(v0, 1, 0, 0, "after_blink");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
